// File: rtl/mcif_rd_arb.sv
// Read-channel arbiter sharing one MCIF read port between the weight and feature-data DMAs.
// Define MCIF_ARB_WT_PRIO_EN for fixed weight priority instead of round-robin.
`timescale 1ns/1ps

module mcif_rd_arb #(
   parameter int LEN_W   = 4,
   parameter int PD_W    = LEN_W + 64,
   parameter int RESP_W  = 64,
   parameter int TRK_DEP = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wt_req_vld,
   output logic              wt_req_rdy,
   input  logic [PD_W-1:0]   wt_req_pd,
   input  logic              dat_req_vld,
   output logic              dat_req_rdy,
   input  logic [PD_W-1:0]   dat_req_pd,
   output logic              mcif_req_vld,
   input  logic              mcif_req_rdy,
   output logic [PD_W-1:0]   mcif_req_pd,
   input  logic              mcif_resp_vld,
   output logic              mcif_resp_rdy,
   input  logic [RESP_W-1:0] mcif_resp_pd,
   output logic              wt_resp_vld,
   input  logic              wt_resp_rdy,
   output logic              dat_resp_vld,
   input  logic              dat_resp_rdy,
   output logic [RESP_W-1:0] resp_pd,
   output logic              idle,
   output logic              err_orphan
);

   typedef enum logic {
      REQ_WT  = 1'b0,
      REQ_DAT = 1'b1
   } req_id_e;

   localparam int AW = (TRK_DEP > 1) ? $clog2(TRK_DEP) : 1;
   typedef logic [AW:0]   cnt_t;
   typedef logic [AW-1:0] ptr_t;
   localparam cnt_t TRK_FULL = cnt_t'(TRK_DEP);

   logic              req_vld_q, req_vld_d;
   logic [PD_W-1:0]   req_pd_q, req_pd_d;
   ptr_t              wr_ptr_q, wr_ptr_d;
   ptr_t              rd_ptr_q, rd_ptr_d;
   cnt_t              trk_cnt_q, trk_cnt_d;
   logic [LEN_W-1:0]  bcnt_q, bcnt_d;
   logic              err_q, err_d;

   req_id_e           trk_id_q  [TRK_DEP];
   logic [LEN_W-1:0]  trk_len_q [TRK_DEP];

   logic              any_req;
   logic              trk_full;
   logic              trk_empty;
   logic              load;
   req_id_e           grant;
   logic [PD_W-1:0]   grant_pd;
   req_id_e           head_id;
   logic [LEN_W-1:0]  head_len;
   logic              beat_acc;
   logic              pop;

`ifndef MCIF_ARB_WT_PRIO_EN
   req_id_e           rr_q, rr_d;
`endif

   assign any_req   = wt_req_vld | dat_req_vld;
   assign trk_full  = (trk_cnt_q == TRK_FULL);
   assign trk_empty = (trk_cnt_q == '0);
   assign load      = !rst & (!req_vld_q | mcif_req_rdy) & !trk_full & any_req;
   assign head_id   = trk_id_q[rd_ptr_q];
   assign head_len  = trk_len_q[rd_ptr_q];

   // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      grant = REQ_WT;
`ifdef MCIF_ARB_WT_PRIO_EN
      if (!wt_req_vld) grant = REQ_DAT;
`else
      if (wt_req_vld && dat_req_vld) grant = rr_q;
      else if (!wt_req_vld)          grant = REQ_DAT;
`endif
   end

   assign grant_pd    = (grant == REQ_DAT) ? dat_req_pd : wt_req_pd;
   assign wt_req_rdy  = load & (grant == REQ_WT);
   assign dat_req_rdy = load & (grant == REQ_DAT);

   // Steering is purely combinational; an empty tracker drains orphan beats.
   always_comb begin
      wt_resp_vld   = 1'b0;
      dat_resp_vld  = 1'b0;
      mcif_resp_rdy = 1'b1;
      if (!trk_empty) begin
         wt_resp_vld   = mcif_resp_vld & (head_id == REQ_WT);
         dat_resp_vld  = mcif_resp_vld & (head_id == REQ_DAT);
         mcif_resp_rdy = (head_id == REQ_DAT) ? dat_resp_rdy : wt_resp_rdy;
      end
   end

   assign beat_acc = mcif_resp_vld & mcif_resp_rdy & !trk_empty;
   assign pop      = beat_acc & (bcnt_q == head_len);

   always_comb begin
      req_vld_d = req_vld_q;
      req_pd_d  = req_pd_q;
      if (load) begin
         req_vld_d = 1'b1;
         req_pd_d  = grant_pd;
      end else if (mcif_req_rdy) begin
         req_vld_d = 1'b0;
      end
   end

   always_comb begin
      wr_ptr_d  = load ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
      rd_ptr_d  = pop  ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
      trk_cnt_d = trk_cnt_q;
      case ({load, pop})
         2'b10:   trk_cnt_d = trk_cnt_q + cnt_t'(1);
         2'b01:   trk_cnt_d = trk_cnt_q - cnt_t'(1);
         default: trk_cnt_d = trk_cnt_q;
      endcase
      bcnt_d = bcnt_q;
      if (beat_acc) bcnt_d = pop ? '0 : bcnt_q + LEN_W'(1);
      err_d = err_q | (mcif_resp_vld & trk_empty);
   end

`ifndef MCIF_ARB_WT_PRIO_EN
   always_comb begin
      rr_d = rr_q;
      if (load) rr_d = (grant == REQ_WT) ? REQ_DAT : REQ_WT;
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_vld_q <= 1'b0;
         req_pd_q  <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         trk_cnt_q <= '0;
         bcnt_q    <= '0;
         err_q     <= 1'b0;
`ifndef MCIF_ARB_WT_PRIO_EN
         rr_q      <= REQ_WT;
`endif
      end else begin
         req_vld_q <= req_vld_d;
         req_pd_q  <= req_pd_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         trk_cnt_q <= trk_cnt_d;
         bcnt_q    <= bcnt_d;
         err_q     <= err_d;
`ifndef MCIF_ARB_WT_PRIO_EN
         rr_q      <= rr_d;
`endif
      end
   end

   // NOTE: tracker storage is not reset; entries are only read while trk_cnt_q says they are valid.
   always_ff @(posedge clk) begin
      if (load) begin
         trk_id_q[wr_ptr_q]  <= grant;
         trk_len_q[wr_ptr_q] <= grant_pd[PD_W-1 -: LEN_W];
      end
   end

   assign mcif_req_vld = req_vld_q;
   assign mcif_req_pd  = req_pd_q;
   assign resp_pd      = mcif_resp_pd;
   assign idle         = !req_vld_q & trk_empty;
   assign err_orphan   = err_q;

endmodule

// File: tb/tb_mcif_rd_arb.sv
// Scoreboard bench for mcif_rd_arb: a queue-based reference model predicts commands and beats.
`timescale 1ns/1ps

module tb_mcif_rd_arb;

   localparam int LEN_W  = 4;
   localparam int PD_W   = LEN_W + 64;
   localparam int RESP_W = 64;
   localparam int DEP    = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              wt_req_vld = 1'b0, dat_req_vld = 1'b0;
   logic              wt_req_rdy, dat_req_rdy;
   logic [PD_W-1:0]   wt_req_pd = '0, dat_req_pd = '0;
   logic              mcif_req_vld;
   logic              mcif_req_rdy = 1'b1;
   logic [PD_W-1:0]   mcif_req_pd;
   logic              mcif_resp_vld = 1'b0;
   logic              mcif_resp_rdy;
   logic [RESP_W-1:0] mcif_resp_pd = '0;
   logic              wt_resp_vld, dat_resp_vld;
   logic              wt_resp_rdy = 1'b1, dat_resp_rdy = 1'b1;
   logic [RESP_W-1:0] resp_pd;
   logic              idle, err_orphan;

   always #5 clk = ~clk;

   mcif_rd_arb #(.LEN_W(LEN_W), .PD_W(PD_W), .RESP_W(RESP_W), .TRK_DEP(DEP)) dut (
      .clk(clk), .rst(rst),
      .wt_req_vld(wt_req_vld), .wt_req_rdy(wt_req_rdy), .wt_req_pd(wt_req_pd),
      .dat_req_vld(dat_req_vld), .dat_req_rdy(dat_req_rdy), .dat_req_pd(dat_req_pd),
      .mcif_req_vld(mcif_req_vld), .mcif_req_rdy(mcif_req_rdy), .mcif_req_pd(mcif_req_pd),
      .mcif_resp_vld(mcif_resp_vld), .mcif_resp_rdy(mcif_resp_rdy), .mcif_resp_pd(mcif_resp_pd),
      .wt_resp_vld(wt_resp_vld), .wt_resp_rdy(wt_resp_rdy),
      .dat_resp_vld(dat_resp_vld), .dat_resp_rdy(dat_resp_rdy),
      .resp_pd(resp_pd), .idle(idle), .err_orphan(err_orphan)
   );

   typedef struct { bit id; int len; } trk_t;
   typedef struct { bit id; logic [RESP_W-1:0] data; } beat_t;

   trk_t            m_trk[$];
   logic [PD_W-1:0] exp_cmd_q[$];
   beat_t           exp_beat_q[$];
   logic [7:0]      obs_q[$];
   bit              m_oreg = 0, m_pref_dat = 0, m_err = 0;
   int              m_bcnt = 0;

   int total = 0, bad = 0;
   int owed = 0;
   int n_wt_acc = 0, n_dat_acc = 0, wt_beats = 0, dat_beats = 0;
   bit rsp_en = 0, rand_rsp_rdy = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [PD_W-1:0] mkpd(input int len, input logic [31:0] f1, input logic [31:0] a);
      return {LEN_W'(len), f1, a};
   endfunction

   // Reference model: outstanding commands as a queue, OREG as a flag.
   always begin : model
      bit   can, win_dat, empty, hid;
      logic exp_rrdy;
      trk_t t;
      @(negedge clk);
      empty = (m_trk.size() == 0);
      hid   = empty ? 1'b0 : m_trk[0].id;
      can   = !rst && (!m_oreg || mcif_req_rdy) && (m_trk.size() < DEP) && (wt_req_vld || dat_req_vld);
`ifdef MCIF_ARB_WT_PRIO_EN
      win_dat = !wt_req_vld;
`else
      win_dat = (wt_req_vld && dat_req_vld) ? m_pref_dat : dat_req_vld;
`endif
      exp_rrdy = empty ? 1'b1 : (hid ? dat_resp_rdy : wt_resp_rdy);
      check("mcif_req_vld", mcif_req_vld, m_oreg);
      check("idle", idle, !m_oreg && empty);
      check("err_orphan", err_orphan, m_err);
      check("wt_req_rdy", wt_req_rdy, can && !win_dat);
      check("dat_req_rdy", dat_req_rdy, can && win_dat);
      check("wt_resp_vld", wt_resp_vld, mcif_resp_vld && !empty && !hid);
      check("dat_resp_vld", dat_resp_vld, mcif_resp_vld && !empty && hid);
      check("mcif_resp_rdy", mcif_resp_rdy, exp_rrdy);
      if (rst) begin
         m_trk.delete(); exp_cmd_q.delete(); exp_beat_q.delete();
         m_oreg = 0; m_pref_dat = 0; m_err = 0; m_bcnt = 0;
      end else begin
         if (mcif_resp_vld && empty) m_err = 1;
         if (mcif_resp_vld && !empty && exp_rrdy) begin
            exp_beat_q.push_back('{id: hid, data: mcif_resp_pd});
            if (m_bcnt == m_trk[0].len) begin
               void'(m_trk.pop_front());
               m_bcnt = 0;
            end else m_bcnt++;
         end
         if (can) begin
            t.id  = win_dat;
            t.len = win_dat ? int'(dat_req_pd[PD_W-1 -: LEN_W]) : int'(wt_req_pd[PD_W-1 -: LEN_W]);
            m_trk.push_back(t);
            exp_cmd_q.push_back(win_dat ? dat_req_pd : wt_req_pd);
            m_oreg = 1;
            m_pref_dat = !win_dat;
         end else if (mcif_req_rdy) m_oreg = 0;
      end
   end

   // Monitor: pops expectations whenever the DUT completes a handshake.
   always begin : monitor
      beat_t b;
      @(negedge clk); #1;
      if (!rst) begin
         if (wt_req_vld && wt_req_rdy) n_wt_acc++;
         if (dat_req_vld && dat_req_rdy) n_dat_acc++;
         if (mcif_req_vld && mcif_req_rdy) begin
            obs_q.push_back(mcif_req_pd[63:56]);
            if (exp_cmd_q.size() == 0) check("cmd_unexpected", 1, 0);
            else check("cmd_pd", mcif_req_pd, exp_cmd_q.pop_front());
         end
         if (wt_resp_vld && wt_resp_rdy) begin
            wt_beats++;
            if (exp_beat_q.size() == 0) check("wt_beat_unexpected", 1, 0);
            else begin
               b = exp_beat_q.pop_front();
               check("wt_beat_id", 0, b.id);
               check("wt_beat_data", resp_pd, b.data);
            end
         end
         if (dat_resp_vld && dat_resp_rdy) begin
            dat_beats++;
            if (exp_beat_q.size() == 0) check("dat_beat_unexpected", 1, 0);
            else begin
               b = exp_beat_q.pop_front();
               check("dat_beat_id", 1, b.id);
               check("dat_beat_data", resp_pd, b.data);
            end
         end
      end
   end

   // MCIF side: beats owed for commands it has accepted.
   always begin : mcif_owed
      @(negedge clk);
      if (rst) owed = 0;
      else begin
         if (mcif_req_vld && mcif_req_rdy) owed += int'(mcif_req_pd[PD_W-1 -: LEN_W]) + 1;
         if (mcif_resp_vld && mcif_resp_rdy && owed > 0) owed--;
      end
   end

   task automatic step();
      @(posedge clk); #1;
      if (rsp_en) begin
         mcif_resp_vld = (owed > 0) && ($urandom_range(0, 3) != 0);
         mcif_resp_pd  = {$urandom(), $urandom()};
      end
      if (rand_rsp_rdy) begin
         wt_resp_rdy  = ($urandom_range(0, 3) != 0);
         dat_resp_rdy = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic look();
      #2;
   endtask

   task automatic do_reset();
      rst = 1; wt_req_vld = 0; dat_req_vld = 0; mcif_resp_vld = 0;
      rsp_en = 0; rand_rsp_rdy = 0; wt_resp_rdy = 1; dat_resp_rdy = 1; mcif_req_rdy = 1;
      repeat (2) step();
      rst = 0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (idle && owed == 0) break;
         step();
      end
      look();
      check(name, (idle === 1'b1) && (owed == 0), 1);
   endtask

   initial begin : watchdog
      #1ms;
      $display("FAIL watchdog: simulation did not end, got timeout want finish");
      $fatal(1);
   end

   initial begin : stim
      int base_w, base_d, nw, nd, bw, bd;
      logic [PD_W-1:0] p0;
      logic [7:0] want;

      do_reset();
      look();
      check("rst_mcif_req_vld", mcif_req_vld, 0);
      check("rst_mcif_req_pd", mcif_req_pd, 0);
      check("rst_err_orphan", err_orphan, 0);
      check("rst_idle", idle, 1);

      // Single weight command, len=3.
      bw = wt_beats; bd = dat_beats;
      wt_req_pd = mkpd(3, 32'h5700_0001, 32'h0000_1000); wt_req_vld = 1;
      step(); wt_req_vld = 0;
      look();
      check("t1_issue_vld", mcif_req_vld, 1);
      check("t1_issue_pd", mcif_req_pd, mkpd(3, 32'h5700_0001, 32'h0000_1000));
      rsp_en = 1;
      wait_idle("t1_idle", 200);
      check("t1_wt_beats", wt_beats - bw, 4);
      check("t1_dat_beats", dat_beats - bd, 0);

      // Both requesters with three commands each.
      do_reset();
      rsp_en = 1;
      base_w = n_wt_acc; base_d = n_dat_acc; obs_q.delete();
      wt_req_pd  = mkpd(0, 32'h5700_0000, 32'h100);
      dat_req_pd = mkpd(1, 32'hDA00_0000, 32'h200);
      wt_req_vld = 1; dat_req_vld = 1;
      for (int i = 0; i < 60; i++) begin
         step();
         nw = n_wt_acc - base_w; nd = n_dat_acc - base_d;
         wt_req_vld  = (nw < 3);
         dat_req_vld = (nd < 3);
         wt_req_pd   = mkpd($urandom_range(0, 3), {8'h57, 24'(nw)}, $urandom());
         dat_req_pd  = mkpd($urandom_range(0, 3), {8'hDA, 24'(nd)}, $urandom());
         if (nw >= 3 && nd >= 3) break;
      end
      for (int i = 0; i < 100 && obs_q.size() < 6; i++) step();
      check("t2_count", obs_q.size(), 6);
      for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
`ifdef MCIF_ARB_WT_PRIO_EN
         want = (i < 3) ? 8'h57 : 8'hDA;
`else
         want = (i % 2 == 1) ? 8'hDA : 8'h57;
`endif
         check($sformatf("t2_order%0d", i), obs_q[i], want);
      end
      wait_idle("t2_idle", 400);

      // MCIF stall, then fill the tracker.
      do_reset();
      mcif_req_rdy = 0;
      base_w = n_wt_acc;
      p0 = mkpd(2, 32'h3300_0000, 32'h0000_3000);
      wt_req_pd = p0; wt_req_vld = 1;
      step();
      wt_req_pd = mkpd(5, 32'h3300_0001, 32'h0000_3100);
      for (int k = 0; k < 5; k++) begin
         step(); look();
         check("t3_hold_pd", mcif_req_pd, p0);
         check("t3_hold_vld", mcif_req_vld, 1);
         check("t3_hold_rdy", wt_req_rdy, 0);
      end
      mcif_req_rdy = 1;
      for (int k = 0; k < 20; k++) begin
         step();
         wt_req_pd = mkpd($urandom_range(0, 15), 32'h3300_0000 | 32'(k), $urandom());
      end
      look();
      check("t3_fill_cnt", n_wt_acc - base_w, 8);
      check("t3_full_rdy", wt_req_rdy, 0);
      check("t3_full_drained", mcif_req_vld, 0);
      rsp_en = 1;
      for (int k = 0; k < 400; k++) begin
         if (n_wt_acc - base_w >= 9) break;
         step();
      end
      check("t3_ninth", n_wt_acc - base_w, 9);
      wt_req_vld = 0;
      wait_idle("t3_idle", 1000);

      // wt(len=1) then dat(len=0); dat stalls three cycles on its beat.
      do_reset();
      bw = wt_beats; bd = dat_beats;
      wt_req_pd = mkpd(1, 32'h5700_00A0, 32'h400); wt_req_vld = 1;
      step(); wt_req_vld = 0;
      dat_req_pd = mkpd(0, 32'hDA00_00A0, 32'h500); dat_req_vld = 1;
      step(); dat_req_vld = 0;
      step(); step();
      wt_resp_rdy = 1; dat_resp_rdy = 0;
      mcif_resp_vld = 1; mcif_resp_pd = 64'hD0D0_0000_0000_0000;
      step(); mcif_resp_pd = 64'hD1D1_0000_0000_0001;
      step(); mcif_resp_pd = 64'hD2D2_0000_0000_0002;
      for (int k = 0; k < 3; k++) begin
         look();
         check("t4_stall_rdy", mcif_resp_rdy, 0);
         check("t4_stall_dat_vld", dat_resp_vld, 1);
         check("t4_stall_wt_vld", wt_resp_vld, 0);
         step();
      end
      dat_resp_rdy = 1;
      look();
      check("t4_release_rdy", mcif_resp_rdy, 1);
      step(); mcif_resp_vld = 0;
      look();
      check("t4_idle", idle, 1);
      check("t4_wt_beats", wt_beats - bw, 2);
      check("t4_dat_beats", dat_beats - bd, 1);

      // Orphan beat with nothing outstanding.
      mcif_resp_vld = 1; mcif_resp_pd = 64'hBAD0;
      look();
      check("t5_orphan_rdy", mcif_resp_rdy, 1);
      check("t5_orphan_wt_vld", wt_resp_vld, 0);
      check("t5_orphan_dat_vld", dat_resp_vld, 0);
      step(); mcif_resp_vld = 0;
      repeat (3) step();
      look();
      check("t5_err_sticky", err_orphan, 1);
      do_reset();
      look();
      check("t5_err_cleared", err_orphan, 0);

      // Randomized traffic, then reset in the middle of it.
      rsp_en = 1; rand_rsp_rdy = 1;
      for (int c = 0; c < 1500; c++) begin
         wt_req_vld   = ($urandom_range(0, 2) == 0);
         dat_req_vld  = ($urandom_range(0, 2) == 0);
         wt_req_pd    = mkpd($urandom_range(0, 15), {8'h57, 24'($urandom())}, $urandom());
         dat_req_pd   = mkpd($urandom_range(0, 15), {8'hDA, 24'($urandom())}, $urandom());
         mcif_req_rdy = ($urandom_range(0, 3) != 0);
         step();
      end
      rst = 1; wt_req_vld = 0; dat_req_vld = 0; mcif_resp_vld = 0;
      rsp_en = 0; rand_rsp_rdy = 0;
      step(); look();
      check("t6_rst_req_vld", mcif_req_vld, 0);
      check("t6_rst_req_pd", mcif_req_pd, 0);
      check("t6_rst_err", err_orphan, 0);
      check("t6_rst_idle", idle, 1);
      check("t6_rst_wt_rdy", wt_req_rdy, 0);
      check("t6_rst_dat_rdy", dat_req_rdy, 0);
      check("t6_rst_wt_rsp", wt_resp_vld, 0);
      check("t6_rst_dat_rsp", dat_resp_vld, 0);
      rst = 0;
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
